// File: rtl/tree_lru_pkg.sv
// Shared definitions for the 8-way tree pseudo-LRU controller:
// tree geometry and FSM state encoding.
package tree_lru_pkg;

  localparam int unsigned TREE_BITS = 7;
  localparam int unsigned LEVELS    = 3;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t UPD   = 2'd1;
  localparam state_t RESP  = 2'd2;
  localparam state_t FLUSH = 2'd3;

endpackage

// File: rtl/tree_lru_ctrl_plru_tree_logic.sv
// Combinational 8-way tree PLRU: victim walk from the root and
// touch update that points every node on the path away from the accessed way.
module plru_tree_logic
  import tree_lru_pkg::*;
(
  input  logic [TREE_BITS-1:0] tree_i,
  input  logic [LEVELS-1:0]    way_i,
  output logic [LEVELS-1:0]    victim_o,
  output logic [TREE_BITS-1:0] tree_o
);

  logic [2:0] vn1, vn2, un1, un2;

  // Victim and update are kept in separate blocks: the parent feeds
  // victim_o back into way_i for victim requests.
  always_comb begin
    vn1         = 3'd1 + {2'b00, tree_i[0]};
    vn2         = 3'd3 + {1'b0, tree_i[0], tree_i[vn1]};
    victim_o[2] = tree_i[0];
    victim_o[1] = tree_i[vn1];
    victim_o[0] = tree_i[vn2];
  end

  always_comb begin
    un1         = 3'd1 + {2'b00, way_i[2]};
    un2         = 3'd3 + {1'b0, way_i[2:1]};
    tree_o      = tree_i;
    tree_o[0]   = ~way_i[2];
    tree_o[un1] = ~way_i[1];
    tree_o[un2] = ~way_i[0];
  end

endmodule

// File: rtl/tree_lru_ctrl.sv
// Tree-PLRU replacement controller: per-set tree array, hit/victim request
// arbitration, victim response channel and a sequential whole-array flush.
module tree_lru_ctrl
  import tree_lru_pkg::*;
#(
  parameter int SET_W = 7,
  parameter int WAY_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hit_valid,
  output logic             o_hit_ready,
  input  logic [SET_W-1:0] i_hit_set,
  input  logic [WAY_W-1:0] i_hit_way,
  input  logic             i_vic_valid,
  output logic             o_vic_ready,
  input  logic [SET_W-1:0] i_vic_set,
  output logic             o_vic_resp_valid,
  input  logic             i_vic_resp_ready,
  output logic [WAY_W-1:0] o_vic_way,
  input  logic             i_flush,
  output logic             o_flush_busy,
  output logic             o_busy
);

  localparam int unsigned NSETS = 2 ** SET_W;

  logic [TREE_BITS-1:0] tree_q [NSETS];

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             pend_q, pend_d;
  logic             vic_q, vic_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [SET_W-1:0] fcnt_q, fcnt_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic [WAY_W-1:0] vway_q, vway_d;

  logic                 wr_en;
  logic [SET_W-1:0]     wr_idx;
  logic [TREE_BITS-1:0] wr_data;
  logic [TREE_BITS-1:0] upd_tree;
  logic [WAY_W-1:0]     victim, upd_way;
  logic                 can_grant, gnt_vic, hs_hit, hs_vic;

  // rr_q=1 prefers the victim channel when both requesters are valid.
  assign can_grant   = (state_q == IDLE) & ~(pend_q | i_flush);
  assign gnt_vic     = i_vic_valid & (~i_hit_valid | rr_q);
  assign o_hit_ready = can_grant & i_hit_valid & ~gnt_vic;
  assign o_vic_ready = can_grant & gnt_vic;
  assign hs_hit      = i_hit_valid & o_hit_ready;
  assign hs_vic      = i_vic_valid & o_vic_ready;

  assign upd_way          = vic_q ? victim : way_q;
  assign o_vic_way        = vway_q;
  assign o_vic_resp_valid = (state_q == RESP);
  assign o_flush_busy     = (state_q == FLUSH);
  assign o_busy           = (state_q != IDLE);

  plru_tree_logic u_plru (
    .tree_i   (tree_q[set_q]),
    .way_i    (upd_way),
    .victim_o (victim),
    .tree_o   (upd_tree)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    pend_d  = pend_q;
    vic_d   = vic_q;
    set_d   = set_q;
    fcnt_d  = fcnt_q;
    way_d   = way_q;
    vway_d  = vway_q;
    wr_en   = 1'b0;
    wr_idx  = set_q;
    wr_data = upd_tree;
    case (state_q)
      IDLE: begin
        if (pend_q | i_flush) begin
          state_d = FLUSH;
          pend_d  = 1'b0;
          fcnt_d  = '0;
        end else if (hs_hit | hs_vic) begin
          state_d = UPD;
          vic_d   = hs_vic;
          set_d   = hs_vic ? i_vic_set : i_hit_set;
          way_d   = hs_hit ? i_hit_way : '0;
          if (i_hit_valid & i_vic_valid) rr_d = hs_hit;
        end
      end
      UPD: begin
        pend_d = pend_q | i_flush;
        wr_en  = 1'b1;
        if (vic_q) begin
          vway_d  = victim;
          state_d = RESP;
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        pend_d = pend_q | i_flush;
        if (i_vic_resp_ready) state_d = IDLE;
      end
      FLUSH: begin
        wr_en   = 1'b1;
        wr_idx  = fcnt_q;
        wr_data = '0;
        fcnt_d  = fcnt_q + 1'b1;
        if (fcnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NSETS; i++) tree_q[i] <= '0;
    end else if (wr_en) begin
      tree_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      pend_q  <= 1'b0;
      vic_q   <= 1'b0;
      set_q   <= '0;
      fcnt_q  <= '0;
      way_q   <= '0;
      vway_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      vic_q   <= vic_d;
      set_q   <= set_d;
      fcnt_q  <= fcnt_d;
      way_q   <= way_d;
      vway_q  <= vway_d;
    end
  end

endmodule

// File: tb/tb_tree_lru_ctrl.sv
// Self-checking bench for tree_lru_ctrl: directed vector table, arbitration,
// response back-pressure, flush and reset corner cases, then random traffic.
module tb_tree_lru_ctrl;

  logic       clk;
  logic       rst;
  logic       i_hit_valid, i_vic_valid, i_vic_resp_ready, i_flush;
  logic [6:0] i_hit_set, i_vic_set;
  logic [2:0] i_hit_way;
  logic       o_hit_ready, o_vic_ready, o_vic_resp_valid, o_flush_busy, o_busy;
  logic [2:0] o_vic_way;

  int errors = 0;
  int checks = 0;

  tree_lru_ctrl #(.SET_W(7), .WAY_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_hit_valid      (i_hit_valid),
    .o_hit_ready      (o_hit_ready),
    .i_hit_set        (i_hit_set),
    .i_hit_way        (i_hit_way),
    .i_vic_valid      (i_vic_valid),
    .o_vic_ready      (o_vic_ready),
    .i_vic_set        (i_vic_set),
    .o_vic_resp_valid (o_vic_resp_valid),
    .i_vic_resp_ready (i_vic_resp_ready),
    .o_vic_way        (o_vic_way),
    .i_flush          (i_flush),
    .o_flush_busy     (o_flush_busy),
    .o_busy           (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one bit per node, walked level by level from the root.
  bit mtree [128][7];

  function automatic int m_victim(input int s);
    int n = 0;
    int w = 0;
    for (int l = 0; l < 3; l++) begin
      int b = int'(mtree[s][n]);
      w = w * 2 + b;
      n = 2 * n + 1 + b;
    end
    return w;
  endfunction

  task automatic m_touch(input int s, input int w);
    int n = 0;
    for (int l = 0; l < 3; l++) begin
      int b = (w >> (2 - l)) & 1;
      mtree[s][n] = (b == 0);
      n = 2 * n + 1 + b;
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < 128; s++)
      for (int n = 0; n < 7; n++) mtree[s][n] = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_hit_valid = 0; i_vic_valid = 0; i_vic_resp_ready = 0; i_flush = 0;
    i_hit_set = '0; i_hit_way = '0; i_vic_set = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({o_hit_ready, o_vic_ready, o_vic_resp_valid,
                               o_flush_busy, o_busy, o_vic_way}), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    m_clear();
  endtask

  // All transaction tasks start and end 1 time unit after a rising edge.
  task automatic hit_txn(input int s, input int w);
    bit acc = 0;
    int waited = 0;
    i_hit_valid = 1; i_hit_set = 7'(s); i_hit_way = 3'(w);
    while (!acc && waited < 50) begin
      @(negedge clk);
      if (o_hit_ready) acc = 1;
      @(posedge clk); #1;
      waited++;
    end
    i_hit_valid = 0; i_hit_set = 7'($urandom); i_hit_way = 3'($urandom);
    if (!acc) chk("hit_accept_timeout", 0, 1);
    else m_touch(s, w);
  endtask

  task automatic vic_txn(input int s, input int hold, input bit flush_in_resp,
                         output int way, output int lat);
    bit acc = 0;
    bit got = 0;
    int waited = 0;
    way = -1; lat = -1;
    i_vic_valid = 1; i_vic_set = 7'(s);
    while (!acc && waited < 50) begin
      @(negedge clk);
      if (o_vic_ready) acc = 1;
      @(posedge clk); #1;
      waited++;
    end
    i_vic_valid = 0; i_vic_set = 7'($urandom);
    if (!acc) begin
      chk("vic_accept_timeout", 0, 1);
      return;
    end
    lat = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (o_vic_resp_valid) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      chk("vic_resp_timeout", 0, 1);
      return;
    end
    way = int'(o_vic_way);
    for (int h = 0; h < hold; h++) begin
      i_hit_valid = 1; i_hit_set = 7'd99;
      i_flush = flush_in_resp && (h == 0);
      @(posedge clk); #1;
      i_flush = 0;
      @(negedge clk);
      chk("hold_resp_valid", int'(o_vic_resp_valid), 1);
      chk("hold_way_stable", int'(o_vic_way), way);
      chk("hold_readies_low", int'({o_hit_ready, o_vic_ready}), 0);
      i_hit_valid = 0;
    end
    i_vic_resp_ready = 1;
    @(posedge clk); #1;
    i_vic_resp_ready = 0;
  endtask

  task automatic vic_model(input string name, input int s, input int hold);
    int e, w, l;
    e = m_victim(s);
    vic_txn(s, hold, 1'b0, w, l);
    chk({name, "_way"}, w, e);
    chk({name, "_lat"}, l, 2);
    m_touch(s, e);
  endtask

  typedef struct {
    bit is_vic;
    int set;
    int way;
    int exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int w, l, n, order, e, waited, qc;
    bit gv;

    tbl[0] = '{1'b1, 5, 0, 0};
    tbl[1] = '{1'b1, 5, 0, 4};
    tbl[2] = '{1'b1, 5, 0, 2};
    tbl[3] = '{1'b0, 3, 0, 0};
    tbl[4] = '{1'b1, 3, 0, 4};
    tbl[5] = '{1'b1, 4, 0, 0};

    do_reset();

    // First cycle after release must already accept a request.
    i_vic_valid = 1; i_vic_set = 7'd5;
    @(negedge clk);
    chk("ready_after_release", int'(o_vic_ready), 1);
    i_vic_valid = 0;
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].is_vic) begin
        e = m_victim(tbl[i].set);
        vic_txn(tbl[i].set, 0, 1'b0, w, l);
        chk($sformatf("tbl%0d_way", i), w, tbl[i].exp);
        chk($sformatf("tbl%0d_lat", i), l, 2);
        m_touch(tbl[i].set, e);
      end else begin
        hit_txn(tbl[i].set, tbl[i].way);
      end
    end

    // Both channels valid: round robin must alternate starting with hit.
    do_reset();
    order = 0;
    i_hit_valid = 1; i_hit_set = 7'd10; i_hit_way = 3'd3;
    i_vic_valid = 1; i_vic_set = 7'd11;
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      while (!(o_hit_ready || o_vic_ready) && waited < 30) begin
        @(negedge clk);
        if (!(o_hit_ready || o_vic_ready)) begin @(posedge clk); #1; end
        waited++;
      end
      chk("arb_one_grant", int'(o_hit_ready & o_vic_ready), 0);
      gv = o_vic_ready;
      @(posedge clk); #1;
      if (gv) begin
        order = order | (1 << g);
        e = m_victim(11);
        waited = 0;
        do begin
          @(negedge clk);
          waited++;
          if (!o_vic_resp_valid) begin @(posedge clk); #1; end
        end while (!o_vic_resp_valid && waited < 20);
        chk("arb_vic_way", int'(o_vic_way), e);
        i_vic_resp_ready = 1;
        @(posedge clk); #1;
        i_vic_resp_ready = 0;
        m_touch(11, e);
      end else begin
        m_touch(10, 3);
      end
    end
    i_hit_valid = 0; i_vic_valid = 0;
    chk("arb_order", order, 4'b1010);
    vic_model("arb_after10", 10, 0);

    // Back-pressured response, then busy drops one edge after ready.
    hit_txn(20, 6);
    vic_model("hold", 20, 5);
    @(negedge clk);
    chk("idle_after_ready", int'(o_busy), 0);
    @(posedge clk); #1;

    // Flush pulse during RESP: pending flush must beat a waiting request.
    hit_txn(30, 1);
    hit_txn(31, 7);
    e = m_victim(30);
    vic_txn(30, 2, 1'b1, w, l);
    chk("fl_vic_way", w, e);
    i_hit_valid = 1; i_hit_set = 7'd30; i_hit_way = 3'd2;
    @(negedge clk);
    chk("pend_blocks_hit", int'(o_hit_ready), 0);
    i_hit_valid = 0;
    n = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (o_flush_busy) begin
        n++;
        i_flush = (n == 60);
      end else if (n > 0) begin
        break;
      end
    end
    i_flush = 0;
    chk("flush_cycles", n, 128);
    qc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      qc += int'(o_flush_busy) + int'(o_busy);
    end
    chk("flush_merged_quiet", qc, 0);
    @(posedge clk); #1;
    m_clear();
    for (int s = 0; s < 128; s++) begin
      e = m_victim(s);
      vic_txn(s, 0, 1'b0, w, l);
      if (s % 16 == 0 || w != 0) chk($sformatf("post_flush_set%0d", s), w, 0);
      m_touch(s, e);
    end

    // Reset during flush at count 40.
    vic_model("dirty9a", 9, 0);
    vic_model("dirty9b", 9, 0);
    i_flush = 1;
    @(posedge clk); #1;
    i_flush = 0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("flush_running", int'(o_flush_busy), 1);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_outputs", int'({o_vic_resp_valid, o_flush_busy, o_busy, o_vic_way}), 0);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    m_clear();
    qc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      qc += int'(o_flush_busy) + int'(o_busy);
    end
    chk("no_flush_after_reset", qc, 0);
    @(posedge clk); #1;
    vic_model("set9_after_reset", 9, 0);

    // Random traffic against the model, small set range for collisions.
    for (int i = 0; i < 300; i++) begin
      int s = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) hit_txn(s, int'($urandom_range(0, 7)));
      else vic_model("rand", s, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
